cpu_mul_result_combiner: RTL and testbench

Downstream neighbour of the CPU multiplier cell. Consumes the three registered 16x16 partial products (lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2)) one cycle after issue and merges them into the low 32 bits of the product. Tags each result with its destination register and buffers results in a small FIFO with a valid/ready handshake to writeback. Issue-side flow control uses credits, so the multiplier cell is never overrun.

---
 rtl/cpu_mul_pkg.sv | 11 +
 rtl/cpu_mul_result_fifo.sv | 54 +++++
 rtl/cpu_mul_result_combiner.sv | 90 +++++++++
 tb/tb_cpu_mul_result_combiner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mul_pkg.sv
// Shared widths and result entry type for the multiplier result path.
package cpu_mul_pkg;
    localparam int MUL_W     = 32;
    localparam int HALF_W    = 16;
    localparam int TAG_W_DEF = 5;

    typedef struct packed {
        logic [MUL_W-1:0]     data;
        logic [TAG_W_DEF-1:0] tag;
    } mul_result_t;
endpackage

// File: rtl/cpu_mul_result_fifo.sv
// First-word-fall-through result buffer with occupancy output and synchronous clear.
module cpu_mul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (occ != '0);
    assign do_push = push && ((occ != OCC_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) mem[wr_ptr] <= wdata;
    end

    // Empty buffer reads as zero so the output is defined straight out of reset.
    assign rdata = (occ != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/cpu_mul_result_combiner.sv
// Merges the three 16x16 partial products into the low 32 product bits,
// tags them and buffers them for writeback under credit-based issue control.
module cpu_mul_result_combiner
    import cpu_mul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             mul_issue,
    input  logic [TAG_W-1:0] mul_tag,
    output logic             issue_ready,
    input  logic [MUL_W-1:0] p1,
    input  logic [MUL_W-1:0] p2,
    input  logic [MUL_W-1:0] p3,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MUL_W-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             err_overflow
);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = OCC_W + 1;

    logic              v0;
    logic              va;
    logic [TAG_W-1:0]  tag_p;
    logic [TAG_W-1:0]  tag_a;
    logic [MUL_W-1:0]  p1_q;
    logic [HALF_W-1:0] cross_q;
    logic [MUL_W-1:0]  sum;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  in_flight;
    logic              push;
    logic              unused_hi;

    // Upper halves of the cross products only reach bits >= 32.
    assign unused_hi = ^{p2[MUL_W-1:HALF_W], p3[MUL_W-1:HALF_W]};

    // Credits count only registered state; a same-cycle pop frees nothing yet.
    assign in_flight   = CNT_W'(occ) + CNT_W'(v0) + CNT_W'(va);
    assign issue_ready = in_flight < CNT_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v0 <= 1'b0;
            va <= 1'b0;
        end else begin
            v0 <= mul_issue & issue_ready;
            va <= v0;
        end
    end

    always_ff @(posedge clk) begin
        if (mul_issue && issue_ready) tag_p <= mul_tag;
        if (v0) begin
            p1_q    <= p1;
            cross_q <= p2[HALF_W-1:0] + p3[HALF_W-1:0];
            tag_a   <= tag_p;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_overflow <= 1'b0;
        else if (!flush && mul_issue && !issue_ready)
            err_overflow <= 1'b1;
    end

    assign sum  = p1_q + {cross_q, {HALF_W{1'b0}}};
    assign push = va & ~flush;

    cpu_mul_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MUL_W + TAG_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .wdata ({sum, tag_a}),
        .pop   (res_valid & res_ready),
        .rdata ({res_data, res_tag}),
        .occ   (occ)
    );

    assign res_valid = (occ != '0);
endmodule

// File: tb/tb_cpu_mul_result_combiner.sv
// Directed bench for the multiplier result combiner with a queue-based reference model.
module tb_cpu_mul_result_combiner;
    import cpu_mul_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = TAG_W_DEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          mul_issue = 1'b0;
    logic [TW-1:0] mul_tag = '0;
    logic          issue_ready;
    logic [31:0]   p1, p2, p3;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [31:0]   res_data;
    logic [TW-1:0] res_tag;
    logic          err_overflow;

    logic [31:0] src1 = '0, src2 = '0;
    logic [31:0] ps1 = '0, ps2 = '0;
    logic        prev_issue = 1'b0;
    logic [31:0] junk1 = '0, junk2 = '0, junk3 = '0;

    int n_checks = 0;
    int n_err = 0;

    cpu_mul_result_combiner #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .mul_issue    (mul_issue),
        .mul_tag      (mul_tag),
        .issue_ready  (issue_ready),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // The multiplier cell presents partials one cycle after any issue attempt; otherwise noise.
    always @(posedge clk) begin
        prev_issue <= mul_issue;
        ps1        <= src1;
        ps2        <= src2;
        junk1      <= $urandom;
        junk2      <= $urandom;
        junk3      <= $urandom;
    end
    assign p1 = prev_issue ? {16'h0, ps1[15:0]} * {16'h0, ps2[15:0]}  : junk1;
    assign p2 = prev_issue ? {16'h0, ps1[15:0]} * {16'h0, ps2[31:16]} : junk2;
    assign p3 = prev_issue ? {16'h0, ps1[31:16]} * {16'h0, ps2[15:0]} : junk3;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted ops become visible two edges after their issue edge.
    typedef struct {
        logic [31:0]   d;
        logic [TW-1:0] t;
        int            due;
    } fl_t;

    fl_t         inflight[$];
    mul_result_t outq[$];
    logic        m_err = 1'b0;
    logic        started = 1'b0;
    int          edge_n = 0;

    always @(posedge clk) begin
        logic m_ready;
        if (reset) begin
            inflight.delete();
            outq.delete();
            m_err   = 1'b0;
            started = 1'b1;
        end else if (flush) begin
            inflight.delete();
            outq.delete();
        end else begin
            m_ready = (outq.size() + inflight.size()) < DEPTH;
            if (outq.size() > 0 && res_ready) void'(outq.pop_front());
            while (inflight.size() > 0 && inflight[0].due == edge_n) begin
                outq.push_back(mul_result_t'{data: inflight[0].d, tag: inflight[0].t});
                void'(inflight.pop_front());
            end
            if (mul_issue) begin
                if (m_ready) inflight.push_back('{d: src1 * src2, t: mul_tag, due: edge_n + 2});
                else m_err = 1'b1;
            end
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("issue_ready", {31'h0, issue_ready},
                  {31'h0, ((outq.size() + inflight.size()) < DEPTH)});
            check("err_overflow", {31'h0, err_overflow}, {31'h0, m_err});
            check("res_valid", {31'h0, res_valid}, {31'h0, outq.size() != 0});
            if (outq.size() != 0) begin
                check("res_data", res_data, outq[0].data);
                check("res_tag", {27'h0, res_tag}, {27'h0, outq[0].tag});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        mul_issue = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int acc;
        tick();
        tick();
        check("rst issue_ready", {31'h0, issue_ready}, 32'h1);
        check("rst res_valid", {31'h0, res_valid}, 32'h0);
        check("rst res_data", res_data, 32'h0);
        check("rst res_tag", {27'h0, res_tag}, 32'h0);
        check("rst err_overflow", {31'h0, err_overflow}, 32'h0);
        reset = 1'b0;
        tick();

        // Single op with exact latency
        mul_issue = 1'b1; mul_tag = 5'd7; src1 = 32'h0001_0003; src2 = 32'h0002_0005;
        tick();
        idle(1);
        check("single not early", {31'h0, res_valid}, 32'h0);
        idle(1);
        check("single valid", {31'h0, res_valid}, 32'h1);
        check("single data", res_data, 32'h000B_000F);
        check("single tag", {27'h0, res_tag}, 32'd7);
        idle(2);

        // Carry out of cross sum and 2^32 overflow are both discarded
        mul_issue = 1'b1; mul_tag = 5'd3; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
        tick();
        idle(2);
        check("wrap valid", {31'h0, res_valid}, 32'h1);
        check("wrap data", res_data, 32'h0000_0001);
        idle(2);

        // Back-to-back at full rate
        for (int i = 0; i < 8; i++) begin
            check("b2b issue_ready", {31'h0, issue_ready}, 32'h1);
            mul_issue = 1'b1; mul_tag = TW'(10 + i);
            src1 = 32'h1234_0000 + 32'(i * 7); src2 = 32'h0003_0011 + 32'(i * 3);
            tick();
            if (i >= 2) check("b2b order", {27'h0, res_tag}, 32'(10 + i - 2));
        end
        idle(1);
        check("b2b order", {27'h0, res_tag}, 32'd16);
        idle(1);
        check("b2b order", {27'h0, res_tag}, 32'd17);
        idle(2);
        check("b2b drained", {31'h0, res_valid}, 32'h0);

        // Backpressure and credit exhaustion
        res_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10 && issue_ready; k++) begin
            mul_issue = 1'b1; mul_tag = TW'(20 + k);
            src1 = 32'hABCD_0100 + 32'(k); src2 = 32'h0F0F_1357 - 32'(k);
            tick();
            acc++;
        end
        check("bp accepted", 32'(acc), 32'd4);
        check("bp issue_ready low", {31'h0, issue_ready}, 32'h0);
        mul_issue = 1'b1; mul_tag = 5'd31; src1 = 32'h5; src2 = 32'h6;
        tick();
        check("bp err set", {31'h0, err_overflow}, 32'h1);
        idle(3);
        check("bp head tag", {27'h0, res_tag}, 32'd20);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp drain tag", {27'h0, res_tag}, 32'(20 + k));
            tick();
        end
        check("bp no 5th", {31'h0, res_valid}, 32'h0);
        idle(2);

        // Flush in the cycle the first result appears
        for (int i = 0; i < 3; i++) begin
            mul_issue = 1'b1; mul_tag = TW'(1 + i); src1 = 32'h0000_0100 + 32'(i); src2 = 32'h9;
            tick();
        end
        mul_issue = 1'b0;
        check("fl first visible", {31'h0, res_valid}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl valid cleared", {31'h0, res_valid}, 32'h0);
        check("fl issue_ready", {31'h0, issue_ready}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fl nothing out", {31'h0, res_valid}, 32'h0);
        end

        // Reset mid-operation
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mul_issue = 1'b1; mul_tag = TW'(5 + i); src1 = 32'h77; src2 = 32'h3 + 32'(i);
            tick();
        end
        idle(3);
        check("rm valid before", {31'h0, res_valid}, 32'h1);
        check("rm err before", {31'h0, err_overflow}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm res_valid", {31'h0, res_valid}, 32'h0);
        check("rm err cleared", {31'h0, err_overflow}, 32'h0);
        check("rm issue_ready", {31'h0, issue_ready}, 32'h1);
        res_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
